// File: rtl/divider_unit_pkg.sv
// Shared execution-unit definitions: FSM state encoding and default
// operand/tag widths used by the divider and multiplier units.
package divider_unit_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_TAG_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } fu_state_e;

endpackage

// File: rtl/divider_unit_step.sv
// One restoring radix-2 division step: trial subtract on a WIDTH+1-bit
// partial remainder, producing one quotient bit and the next remainder.
module divider_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dsr,
  output logic             qbit,
  output logic [WIDTH-1:0] rem_next
);

  logic [WIDTH:0] part;
  logic [WIDTH:0] trial;

  // rem < dsr always holds, so the top bit of trial is a clean borrow
  always_comb begin
    part     = {rem, dvd_msb};
    trial    = part - {1'b0, dsr};
    qbit     = ~trial[WIDTH];
    rem_next = qbit ? trial[WIDTH-1:0] : part[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_unit.sv
// Iterative signed/unsigned integer divider execution unit.
// Optional in-flight kill port enabled by DIVIDER_UNIT_FLUSH_EN.
module divider_unit
  import divider_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issuediv_enable,
  input  logic             issuediv_signed,
  input  logic [WIDTH-1:0] issuediv_rsdata,
  input  logic [WIDTH-1:0] issuediv_rtdata,
  input  logic [TAG_W-1:0] issuediv_rdtag,
`ifdef DIVIDER_UNIT_FLUSH_EN
  input  logic             issuediv_flush,
`endif
  output logic             issuediv_busy,
  output logic             issuediv_valid,
  output logic [WIDTH-1:0] issuediv_quot,
  output logic [WIDTH-1:0] issuediv_rem,
  output logic             issuediv_dbz,
  output logic [TAG_W-1:0] issuediv_rdtag_out
);

  localparam int CW = $clog2(WIDTH);

  fu_state_e        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] prem;
  logic             qneg;
  logic             rneg;
  logic             dbz_r;
  logic [TAG_W-1:0] tag_r;

  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;
  logic             rt_zero;
  logic             qbit;
  logic [WIDTH-1:0] rem_next;
  logic             kill;

  always_comb begin
    rs_neg  = issuediv_signed & issuediv_rsdata[WIDTH-1];
    rt_neg  = issuediv_signed & issuediv_rtdata[WIDTH-1];
    rs_mag  = rs_neg ? -issuediv_rsdata : issuediv_rsdata;
    rt_mag  = rt_neg ? -issuediv_rtdata : issuediv_rtdata;
    rt_zero = (issuediv_rtdata == '0);
  end

`ifdef DIVIDER_UNIT_FLUSH_EN
  assign kill = issuediv_flush &&
                (state == ST_ITER || state == ST_FIX);
`else
  assign kill = 1'b0;
`endif

  divider_unit_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (prem),
    .dvd_msb (dvd[WIDTH-1]),
    .dsr     (dsr),
    .qbit    (qbit),
    .rem_next(rem_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      cnt                <= '0;
      dvd                <= '0;
      dsr                <= '0;
      prem               <= '0;
      qneg               <= 1'b0;
      rneg               <= 1'b0;
      dbz_r              <= 1'b0;
      tag_r              <= '0;
      issuediv_busy      <= 1'b0;
      issuediv_valid     <= 1'b0;
      issuediv_quot      <= '0;
      issuediv_rem       <= '0;
      issuediv_dbz       <= 1'b0;
      issuediv_rdtag_out <= '0;
    end else begin
      issuediv_valid <= 1'b0;
      if (kill) begin
        state         <= ST_IDLE;
        issuediv_busy <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE, ST_DONE: begin
            if (issuediv_enable) begin
              tag_r <= issuediv_rdtag;
              qneg  <= rs_neg ^ rt_neg;
              rneg  <= rs_neg;
              dsr   <= rt_mag;
              prem  <= '0;
              cnt   <= CW'(WIDTH - 1);
              if (!rt_zero) begin
                dbz_r         <= 1'b0;
                dvd           <= rs_mag;
                state         <= ST_ITER;
                issuediv_busy <= 1'b1;
              end else if (state == ST_DONE) begin
                // detour via FIX so valid never pulses twice in a row
                dbz_r         <= 1'b1;
                dvd           <= issuediv_rsdata;
                state         <= ST_FIX;
                issuediv_busy <= 1'b1;
              end else begin
                dbz_r              <= 1'b1;
                issuediv_quot      <= '1;
                issuediv_rem       <= issuediv_rsdata;
                issuediv_dbz       <= 1'b1;
                issuediv_rdtag_out <= issuediv_rdtag;
                issuediv_valid     <= 1'b1;
                state              <= ST_DONE;
                issuediv_busy      <= 1'b0;
              end
            end else begin
              state         <= ST_IDLE;
              issuediv_busy <= 1'b0;
            end
          end
          ST_ITER: begin
            dvd  <= {dvd[WIDTH-2:0], qbit};
            prem <= rem_next;
            cnt  <= cnt - CW'(1);
            if (cnt == '0) begin
              state <= ST_FIX;
            end
          end
          ST_FIX: begin
            state              <= ST_DONE;
            issuediv_busy      <= 1'b0;
            issuediv_valid     <= 1'b1;
            issuediv_rdtag_out <= tag_r;
            issuediv_dbz       <= dbz_r;
            if (dbz_r) begin
              issuediv_quot <= '1;
              issuediv_rem  <= dvd;
            end else begin
              issuediv_quot <= qneg ? -dvd : dvd;
              issuediv_rem  <= rneg ? -prem : prem;
            end
          end
          default: begin
            state         <= ST_IDLE;
            issuediv_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
